// File: rtl/rs_ctrl_pkg.sv
// Shared types for the RS latch sequencer: FSM states, op encodings, sizing helper.
// Combinational definitions only; no latency, no backpressure.
package rs_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic OP_RESET = 1'b0;
  localparam logic OP_SET   = 1'b1;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick of the first asserted request at or after ptr, wrapping.
// Purely combinational (zero latency); no backpressure, the caller registers the result.
module rr_arbiter
  import rs_ctrl_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx
);

  logic [NREQ-1:0] hi;

  // Lowest-index request at or above ptr wins; otherwise wrap to the lowest request overall.
  always_comb begin
    hi  = '0;
    idx = '0;
    gnt = '0;
    for (int i = 0; i < NREQ; i++) begin
      hi[i] = req[i] && (IW'(i) >= ptr);
    end
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) idx = IW'(i);
    end
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (hi[i]) idx = IW'(i);
    end
    if (|req) gnt = {{(NREQ-1){1'b0}}, 1'b1} << idx;
  end

endmodule

// File: rtl/rs_latch_ctrl.sv
// Arbitrates NREQ requesters onto one RS latch: fixed-width active-low pulse, recovery gap, q check.
// Grant one cycle after request, done after PULSE_W+GAP_W+1; other requests wait while busy.
module rs_latch_ctrl
  import rs_ctrl_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int PULSE_W = 2,
  parameter int GAP_W   = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] op,
  output logic [NREQ-1:0] grant,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic            set_n,
  output logic            reset_n,
  input  logic            q
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(max_int(PULSE_W, GAP_W) + 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            op_q, op_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            set_n_q, set_n_d;
  logic            reset_n_q, reset_n_d;

  logic [NREQ-1:0] arb_gnt;
  logic [IW-1:0]   arb_idx;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req (req),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = PULSE;
          cnt_d   = CW'(PULSE_W - 1);
          grant_d = arb_gnt;
          idx_d   = arb_idx;
          op_d    = |(op & arb_gnt);
        end
      end
      PULSE: begin
        if (cnt_q == '0) begin
          state_d = GAP;
          cnt_d   = CW'(GAP_W - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        grant_d = '0;
        ptr_d   = (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + IW'(1);
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase

    // Outputs follow the next state so every pin comes straight from a flop.
    set_n_d   = !(state_d == PULSE && op_d == OP_SET);
    reset_n_d = !(state_d == PULSE && op_d == OP_RESET);
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
    err_d     = (state_d == DONE) && (q != op_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= OP_RESET;
      idx_q     <= '0;
      ptr_q     <= '0;
      grant_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      set_n_q   <= 1'b1;
      reset_n_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      idx_q     <= idx_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      set_n_q   <= set_n_d;
      reset_n_q <= reset_n_d;
    end
  end

  assign grant   = grant_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign set_n   = set_n_q;
  assign reset_n = reset_n_q;

endmodule
